alu_mc: RTL and testbench

- Parametrised multi-cycle integer ALU. It is the next generation of the team's 1-bit and/or/add slice.
- Widened to WIDTH bits, with 8 operations, status flags and valid/ready handshakes on both sides.
- Shifts use an iterative 1-bit-per-cycle shifter by default. All other ops complete in one cycle.
- Sits between the decode/issue stage and writeback of the riscv_soc integer pipeline. Also usable as a standalone coprocessor ALU.

---
 rtl/alu_mc.sv | 219 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle integer ALU with valid/ready handshakes.
//
// Eight operations (AND, OR, ADD, SUB, XOR, SLT, SLL, SRL) on WIDTH-bit
// operands, with carry, zero and signed-overflow flags. Non-shift ops take
// one cycle. Shifts use an iterative 1-bit-per-cycle shifter unless the
// ALU_MC_FAST_SHIFT_EN macro is defined. With the macro defined, a
// combinational barrel shifter is used and the SHIFT state and its counter
// are not built. Results are the same in both builds; only latency differs.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request side: valid_i/ready_o, accepted only in IDLE.
// Response side: valid_o/ready_i. The result and flags stay stable while
// valid_o=1 and ready_i=0.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   valid_i    request valid
//   ready_o    ALU can accept a request (state == IDLE)
//   a_i, b_i   operands; b_i[SHW-1:0] is the shift amount for shifts
//   c_in       carry-in, used by ADD only
//   op_i       000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT,
//              110 SLL, 111 SRL
//   valid_o    result valid (state == DONE)
//   ready_i    consumer accepts the result
//   result     registered result
//   c_out      carry flag (SUB: 1 = no borrow)
//   zero       result == 0
//   ovf        signed overflow (ADD/SUB only)
//   state_dbg  current FSM state, for debug/observation
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in,
  input  logic [2:0]       op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] calc_res;
  logic             calc_c;
  logic             calc_ovf;
  logic             load_now;

  assign shamt = b_i[SHW-1:0];

  // Single-cycle datapath. ADD and SUB share one adder: SUB feeds ~b with a
  // forced carry-in of 1, so the adder carry-out is the "no borrow" flag and
  // the overflow rule is the same for both (operand signs equal, sum sign
  // differs) when applied to the effective B operand.
  always_comb begin
    b_eff    = b_i;
    cin_eff  = c_in;
    if (op_i == OP_SUB) begin
      b_eff   = ~b_i;
      cin_eff = 1'b1;
    end
    sum_ext  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    calc_res = '0;
    calc_c   = 1'b0;
    calc_ovf = 1'b0;
    case (op_i)
      OP_AND: calc_res = a_i & b_i;
      OP_OR:  calc_res = a_i | b_i;
      OP_XOR: calc_res = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        calc_res = sum_ext[WIDTH-1:0];
        calc_c   = sum_ext[WIDTH];
        calc_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLT: calc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_MC_FAST_SHIFT_EN
      OP_SLL: calc_res = a_i << shamt;
      OP_SRL: calc_res = a_i >> shamt;
`else
      // Only reached with a zero shift amount; non-zero amounts go through
      // the SHIFT state.
      OP_SLL, OP_SRL: calc_res = a_i;
`endif
      default: calc_res = '0;
    endcase
  end

`ifndef ALU_MC_FAST_SHIFT_EN
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             dir_left_q;
  logic [WIDTH-1:0] work_next;
  logic             start_shift;
  logic             is_shift;

  assign is_shift  = (op_i == OP_SLL) || (op_i == OP_SRL);
  assign work_next = dir_left_q ? {work_q[WIDTH-2:0], 1'b0}
                                : {1'b0, work_q[WIDTH-1:1]};
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    load_now = 1'b0;
`ifndef ALU_MC_FAST_SHIFT_EN
    start_shift = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
`ifdef ALU_MC_FAST_SHIFT_EN
          load_now = 1'b1;
          state_d  = DONE;
`else
          if (is_shift && (shamt != '0)) begin
            start_shift = 1'b1;
            state_d     = SHIFT;
          end else begin
            load_now = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end
`ifndef ALU_MC_FAST_SHIFT_EN
      SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
`endif
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      result  <= '0;
      c_out   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_now) begin
        result <= calc_res;
        c_out  <= calc_c;
        zero   <= (calc_res == '0);
        ovf    <= calc_ovf;
      end
`ifndef ALU_MC_FAST_SHIFT_EN
      // Final shift step: the result register is written only here, so no
      // partially shifted value is ever visible.
      if ((state_q == SHIFT) && (cnt_q == SHW'(1))) begin
        result <= work_next;
        c_out  <= 1'b0;
        zero   <= (work_next == '0);
        ovf    <= 1'b0;
      end
`endif
    end
  end

`ifndef ALU_MC_FAST_SHIFT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else if (start_shift) begin
      work_q     <= a_i;
      cnt_q      <= shamt;
      dir_left_q <= (op_i == OP_SLL);
    end else if (state_q == SHIFT) begin
      work_q <= work_next;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end
`endif

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc at WIDTH=8.
// Expected values are hand-computed constants held in a vector table; the
// expected results are queued at issue and popped at completion.
// ---------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 8;

`ifdef ALU_MC_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // ---------------- clock / reset ----------------
  logic         clk     = 1'b0;
  logic         rst_i   = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         c_in    = 1'b0;
  logic [2:0]   op_i    = 3'b000;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         ready_o, valid_o, c_out, zero, ovf;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_in      (c_in),
    .op_i      (op_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result    (result),
    .c_out     (c_out),
    .zero      (zero),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the first falling edge after the
  // accept edge, with request inputs scrambled to show they are not used.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    int guard = 0;
    while (!ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", 32'(ready_o), 32'd1);
    op_i = op; a_i = a; b_i = b; c_in = cin; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    op_i = 3'($urandom_range(0, 7));
    a_i  = W'($urandom_range(0, 255));
    b_i  = W'($urandom_range(0, 255));
    c_in = 1'($urandom_range(0, 1));
  endtask

  // Counts cycles from the accept edge until valid_o; also notes whether
  // ready_o was ever seen high while busy.
  task automatic wait_done(output int lat, output logic busy_ready_seen);
    lat = 1;
    busy_ready_seen = 1'b0;
    while (!valid_o && lat < 40) begin
      if (ready_o) busy_ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("back_to_idle_ready", 32'(ready_o), 32'd1);
    check("back_to_idle_valid", 32'(valid_o), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int         lat;
    logic       busy_rdy;
    logic [W-1:0] exp_res;
    exp_q.push_back(v.res);
    issue(v.op, v.a, v.b, v.cin);
    wait_done(lat, busy_rdy);
    exp_res = exp_q.pop_front();
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_busy_ready"}, 32'(busy_rdy), 32'd0);
    check({v.name, "_result"}, 32'(result), 32'(exp_res));
    check({v.name, "_c_out"}, 32'(c_out), 32'(v.c));
    check({v.name, "_zero"}, 32'(zero), 32'(v.z));
    check({v.name, "_ovf"}, 32'(ovf), 32'(v.v));
    consume();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   lat;
    logic busy_rdy;

    vecs.push_back('{"add_ff_01",   OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{"sub_80_01",   OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"and_f0_3c",   OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"or_f0_3c",    OP_OR,  8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"xor_f0_3c",   OP_XOR, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"slt_fe_01",   OP_SLT, 8'hFE, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"slt_01_fe",   OP_SLT, 8'h01, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"sll_01_5",    OP_SLL, 8'h01, 8'h05, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, FAST ? 1 : 6});
    vecs.push_back('{"srl_f0_0",    OP_SRL, 8'hF0, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"srl_80_7",    OP_SRL, 8'h80, 8'h07, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, FAST ? 1 : 8});
    vecs.push_back('{"sll_81_1",    OP_SLL, 8'h81, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, FAST ? 1 : 2});
    vecs.push_back('{"srl_01_1",    OP_SRL, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, FAST ? 1 : 2});
    vecs.push_back('{"add_7f_01_c", OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{"sub_05_05",   OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{"sub_00_01",   OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"add_12_34",   OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1});

    // Reset: outputs clear without a clock edge.
    #1 rst_i = 1'b1;
    #1;
    check("reset_result",  32'(result),  32'd0);
    check("reset_c_out",   32'(c_out),   32'd0);
    check("reset_zero",    32'(zero),    32'd0);
    check("reset_ovf",     32'(ovf),     32'd0);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: hold ready_i low in DONE, pulse valid_i, expect no change.
    exp_q.push_back(8'h30);
    issue(OP_ADD, 8'h10, 8'h20, 1'b0);
    wait_done(lat, busy_rdy);
    check("bp_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 3; i++) begin
      valid_i = (i != 1);
      op_i = OP_XOR; a_i = 8'hAA; b_i = 8'h55;
      check("bp_valid_o", 32'(valid_o), 32'd1);
      check("bp_ready_o", 32'(ready_o), 32'd0);
      check("bp_result",  32'(result),  32'(exp_q[0]));
      check("bp_zero",    32'(zero),    32'd0);
      check("bp_c_out",   32'(c_out),   32'd0);
      @(negedge clk);
    end
    valid_i = 1'b0;
    check("bp_result_held", 32'(result), 32'(exp_q.pop_front()));
    check("bp_valid_held",  32'(valid_o), 32'd1);
    consume();
    @(negedge clk);
    check("bp_no_accept_valid", 32'(valid_o), 32'd0);
    check("bp_no_accept_ready", 32'(ready_o), 32'd1);

    // Reset mid-shift: SLL by 7, three cycles in.
    issue(OP_SLL, 8'h03, 8'h07, 1'b0);
    repeat (2) @(negedge clk);
    if (!FAST) begin
      check("mid_shift_valid_o", 32'(valid_o), 32'd0);
      check("mid_shift_ready_o", 32'(ready_o), 32'd0);
      check("mid_shift_result",  32'(result),  32'h30);
    end
    rst_i = 1'b1;
    valid_i = 1'b1; op_i = OP_ADD; a_i = 8'h01; b_i = 8'h01;
    #1;
    check("rst_mid_valid_o", 32'(valid_o), 32'd0);
    check("rst_mid_result",  32'(result),  32'd0);
    check("rst_mid_c_out",   32'(c_out),   32'd0);
    check("rst_mid_ovf",     32'(ovf),     32'd0);
    check("rst_mid_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b0;
    valid_i = 1'b0;
    check("post_rst_ready_o", 32'(ready_o), 32'd1);
    check("post_rst_valid_o", 32'(valid_o), 32'd0);
    check("post_rst_result",  32'(result),  32'd0);

    run_vec('{"add_after_rst", OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1});

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
